mux_n_rr_reg: RTL and testbench

- Parametrised successor to the 2:1 / 4-bit mux cells: an N_CH-channel, WIDTH-bit multiplexer with a registered output and a valid/ready handshake on every channel.
- Selects either a fixed channel (like the S select of the 2:1 mux) or round-robin among requesting channels.
- Sits between several producers and one registered consumer in the gate-delay test designs.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter_n.sv | 43 ++++
 rtl/mux_n_rr_reg.sv | 143 ++++++++++++++
 tb/tb_mux_n_rr_reg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// +-----------------------------------------------------------------------+
// | Package : mux_pkg                                                     |
// | Shared mode constants and a constant-evaluable clog2 helper for the   |
// | round-robin registered multiplexer.                                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceiling log2, used to size channel-index fields from the channel count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_n.sv
// +-----------------------------------------------------------------------+
// | Module  : rr_arbiter_n                                                |
// | Round-robin arbiter: grants the first requester found searching from  |
// | ptr upward with wrap. Outputs a one-hot grant and its index.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter_n #(
  parameter int N_CH = 4,
  parameter int SELW = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  localparam logic [SELW:0] N_CH_W = (SELW+1)'(N_CH);

  // Rotating priority search; the first hit wins and later hits are ignored.
  always_comb begin : p_search
    logic [SELW:0] cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr} + (SELW+1)'(k);
      if (cand >= N_CH_W) cand = cand - N_CH_W;
      if (en && !gnt_valid && req[cand[SELW-1:0]]) begin
        gnt_valid                = 1'b1;
        gnt_idx                  = cand[SELW-1:0];
        gnt[cand[SELW-1:0]]      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_rr_reg.sv
// +-----------------------------------------------------------------------+
// | Module  : mux_n_rr_reg                                                |
// | N_CH-channel WIDTH-bit multiplexer with registered output and         |
// | valid/ready handshake; fixed-select or round-robin arbitration.       |
// | Optional: MUX_N_RR_TOGGLE_CNT_EN adds an output toggle counter.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module mux_n_rr_reg
  import mux_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  N_CH  = 4,
  parameter int  SELW  = clog2(N_CH),
  parameter real PwrC  = 0.000015
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  mode,
  input  logic [SELW-1:0]       S,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      Q,
  output logic                  out_valid,
  output logic [SELW-1:0]       out_sel,
  input  logic                  out_ready
`ifdef MUX_N_RR_TOGGLE_CNT_EN
  ,
  output logic [31:0]           toggle_cnt
`endif
);

  localparam logic [SELW:0] N_CH_W = (SELW+1)'(N_CH);

  logic [SELW-1:0]  rr_ptr;
  logic             load;
  logic [N_CH-1:0]  arb_gnt;
  logic [SELW-1:0]  arb_idx;
  logic             arb_valid;
  logic             fixed_ok;
  logic [N_CH-1:0]  fixed_gnt;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [N_CH-1:0]  grant_vec;
  logic             xfer;
  logic [WIDTH-1:0] data_sel;
  logic [SELW:0]    ptr_inc;
  logic [SELW-1:0]  ptr_next;

  // Output register can take a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  rr_arbiter_n #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .en        (mode == MODE_RR),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Fixed-select grant; an out-of-range S never grants.
  always_comb begin
    fixed_gnt = '0;
    fixed_ok  = ({1'b0, S} < N_CH_W) && in_valid[S];
    if (fixed_ok) fixed_gnt[S] = 1'b1;
  end

  // Pick the active grant source and derive ready/transfer from it.
  always_comb begin
    if (mode == MODE_FIXED) begin
      grant_valid = fixed_ok;
      grant_idx   = S;
      grant_vec   = fixed_gnt;
    end else begin
      grant_valid = arb_valid;
      grant_idx   = arb_idx;
      grant_vec   = arb_gnt;
    end
    xfer     = load && grant_valid && !Reset;
    in_ready = xfer ? grant_vec : '0;
  end

  // Data mux and wrapped successor of the granted index.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SELW'(i)) data_sel = in_data[i*WIDTH +: WIDTH];
    end
    ptr_inc  = {1'b0, grant_idx} + (SELW+1)'(1);
    ptr_next = (ptr_inc == N_CH_W) ? '0 : ptr_inc[SELW-1:0];
  end

  // Output register, valid flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Q         <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      Q         <= data_sel;
      out_sel   <= grant_idx;
      out_valid <= 1'b1;
      if (mode == MODE_RR) rr_ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_N_RR_TOGGLE_CNT_EN
  logic [31:0] toggles;
  logic [32:0] cnt_sum;
  real         energy;

  // Bits of Q that flip on the coming update, added to the running total.
  always_comb begin
    toggles = '0;
    for (int i = 0; i < WIDTH; i++) toggles = toggles + 32'(Q[i] ^ data_sel[i]);
    cnt_sum = {1'b0, toggle_cnt} + {1'b0, toggles};
  end

  // Saturating toggle accumulator.
  always_ff @(posedge clk) begin
    if (Reset)     toggle_cnt <= '0;
    else if (xfer) toggle_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  // Energy estimate for power reporting in simulation.
  always_comb energy = real'(toggle_cnt) * PwrC;
`else
  logic unused_pwrc;
  assign unused_pwrc = (PwrC < 0.0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_n_rr_reg.sv
// +-----------------------------------------------------------------------+
// | Module  : tb_mux_n_rr_reg                                             |
// | Self-checking bench: directed scenarios plus random traffic compared  |
// | against a cycle-level behavioural model of the multiplexer.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mux_n_rr_reg;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           Reset;
  logic           mode;
  logic [1:0]     S;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   Q;
  logic           out_valid;
  logic [1:0]     out_sel;
  logic           out_ready;
`ifdef MUX_N_RR_TOGGLE_CNT_EN
  logic [31:0]    toggle_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;

  // Reference state: what the output register should hold.
  int m_q, m_ov, m_sel, m_ptr;
  longint m_cnt;

  always #5 clk = ~clk;

  mux_n_rr_reg #(.WIDTH(W), .N_CH(N), .SELW(2)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .mode      (mode),
    .S         (S),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_N_RR_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Channel chosen by the arbitration rules, or -1 if none.
  function automatic int model_grant();
    if (mode) return (in_valid[S] === 1'b1) ? int'(S) : -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model over the edge.
  task automatic tick();
    int  g, ld, nq;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g  = model_grant();
    ld = (!m_ov || out_ready) ? 1 : 0;
    exp_rdy = (Reset || !ld || g < 0) ? '0 : (N'(1) << g);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("Q", 32'(Q), 32'(m_q));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_sel", 32'(out_sel), 32'(m_sel));
`ifdef MUX_N_RR_TOGGLE_CNT_EN
    check("toggle_cnt", toggle_cnt, 32'(m_cnt));
`endif
    @(posedge clk);
    #1;
    if (Reset) begin
      m_q = 0; m_ov = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (ld && g >= 0) begin
      nq    = int'(in_data[g*W +: W]);
      m_cnt = m_cnt + $countones(W'(m_q ^ nq));
      if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
      m_q   = nq;
      m_sel = g;
      m_ov  = 1;
      if (!mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  initial begin
    Reset = 1'b1; mode = 1'b0; S = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 16'h4321;
    @(posedge clk); #1;
    m_q = 0; m_ov = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;

    // Reset held with all channels valid.
    tick(); tick();
    check("reset_q", 32'(Q), 0);
    check("reset_ov", 32'(out_valid), 0);

    // Round-robin with all channels valid: 1,2,3,4,1.
    Reset = 1'b0;
    tick(); check("rr_seq0", 32'(Q), 32'h1);
    tick(); check("rr_seq1", 32'(Q), 32'h2);
    tick(); check("rr_seq2", 32'(Q), 32'h3);
    tick(); check("rr_seq3", 32'(Q), 32'h4);
    tick(); check("rr_seq4", 32'(Q), 32'h1); check("rr_sel4", 32'(out_sel), 0);

    // Fixed select channel 2, then drop its valid.
    mode = 1'b1; S = 2'd2;
    tick(); tick(); tick();
    check("fixed_q", 32'(Q), 32'h3);
    check("fixed_rdy", 32'(in_ready), 32'h4);
    in_valid = 4'b1011;
    tick();
    check("fixed_nordy", 32'(in_ready), 0);
    tick();
    check("fixed_drop", 32'(out_valid), 0);

    // Back-pressure after the first beat.
    Reset = 1'b1; mode = 1'b0; in_valid = 4'hF;
    tick();
    Reset = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_q", 32'(Q), 32'h1);
      check("bp_hold_ov", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next", 32'(Q), 32'h2);

    // Sparse round-robin: pointer at 2, channels 1 and 3 valid.
    in_valid = 4'b1010;
    tick(); check("sparse_a", 32'(out_sel), 3);
    tick(); check("sparse_b", 32'(out_sel), 1);
    tick(); check("sparse_c", 32'(out_sel), 3);

    // Reset while a beat is held under back-pressure.
    out_ready = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    check("midrst_ov", 32'(out_valid), 0);
    check("midrst_q", 32'(Q), 0);
    Reset = 1'b0; out_ready = 1'b1; in_valid = 4'h0;
    tick();
    check("midrst_noreemit", 32'(out_valid), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_data   = 16'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      S         = 2'($urandom);
      Reset     = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
